// File: rtl/fifo_ctrl_64x22.sv
// fifo_ctrl_64x22: pointer/count/flag controller that turns a 64x22 two-port
// register file into a synchronous FIFO. Pushes become port-B writes, pops
// become port-A reads; read data comes straight from the RAM output register.
module fifo_ctrl_64x22 #(
  parameter int unsigned WIDTH       = 22,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned AFULL_LEVEL = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WIDTH-1:0]  din,
  input  logic              pop,
  input  logic              flush,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic              underflow,
  output logic [WIDTH-1:0]  ram_db,
  output logic [ADDR_W-1:0] ram_ab,
  output logic              ram_cenb_n,
  input  logic [WIDTH-1:0]  ram_qa,
  output logic [ADDR_W-1:0] ram_aa,
  output logic              ram_cena_n
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_LEVEL);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              push_ok, pop_ok;

  // Acceptance from start-of-cycle flags, and the RAM port drive.
  always_comb begin
    push_ok    = push & ~full_q  & ~reset & ~flush;
    pop_ok     = pop  & ~empty_q & ~reset & ~flush;
    ram_ab     = wr_ptr_q;
    ram_db     = din;
    ram_cenb_n = ~push_ok;
    ram_aa     = rd_ptr_q;
    ram_cena_n = ~pop_ok;
  end

  // Next-state for pointers, occupancy, flags and sticky errors.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    dout_valid_d = pop_ok;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      if (push & full_q)  overflow_d  = 1'b1;
      if (pop  & empty_q) underflow_d = 1'b1;
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    afull_d = (count_d >= AFULL_C);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      afull_q      <= 1'b0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      afull_q      <= afull_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Output aliases of registered state.
  always_comb begin
    dout        = ram_qa;
    dout_valid  = dout_valid_q;
    full        = full_q;
    empty       = empty_q;
    almost_full = afull_q;
    fifo_count  = count_q;
    overflow    = overflow_q;
    underflow   = underflow_q;
  end

endmodule
